// File: rtl/trace_pkg.sv
// Shared types for the retirement-trace checker:
// flag indices, failure codes, states and the record layout.
package trace_pkg;

  localparam int FL_REGWRITE = 0;
  localparam int FL_MEMWRITE = 1;
  localparam int FL_MEMREAD  = 2;
  localparam int FL_HALT     = 3;

  localparam logic [2:0] FC_NONE      = 3'd0;
  localparam logic [2:0] FC_FLAGS     = 3'd1;
  localparam logic [2:0] FC_PC        = 3'd2;
  localparam logic [2:0] FC_REG       = 3'd3;
  localparam logic [2:0] FC_WDATA     = 3'd4;
  localparam logic [2:0] FC_ADDR      = 3'd5;
  localparam logic [2:0] FC_MDATA     = 3'd6;
  localparam logic [2:0] FC_UNDERFLOW = 3'd7;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PASS = 2'd1,
    FAIL = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0]  flags;
    logic [15:0] pc;
    logic [2:0]  rd;
    logic [15:0] wdata;
    logic [15:0] addr;
    logic [15:0] mdata;
  } rec_t;

  // First mismatching field; flags are known equal past the first test.
  function automatic logic [2:0] cmpRec(rec_t e, rec_t o);
    logic [2:0] c;
    logic memAcc;
    c = FC_NONE;
    memAcc = e.flags[FL_MEMREAD] | e.flags[FL_MEMWRITE];
    if (e.flags != o.flags)
      c = FC_FLAGS;
    else if (e.pc != o.pc)
      c = FC_PC;
    else if (e.flags[FL_REGWRITE] && e.rd != o.rd)
      c = FC_REG;
    else if (e.flags[FL_REGWRITE] && e.wdata != o.wdata)
      c = FC_WDATA;
    else if (memAcc && e.addr != o.addr)
      c = FC_ADDR;
    else if (e.flags[FL_MEMWRITE] && e.mdata != o.mdata)
      c = FC_MDATA;
    return c;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO of expected commit records.
// Pointers carry an extra MSB to tell full from empty.
module trace_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 71
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic          doPush;
  logic          doPop;

  assign empty  = (wrPtr == rdPtr);
  assign full   = (wrPtr[AW] != rdPtr[AW]) &&
                  (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign dout   = mem[rdPtr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (doPush)
      mem[wrPtr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush)
        wrPtr <= wrPtr + PW'(1);
      if (doPop)
        rdPtr <= rdPtr + PW'(1);
    end
  end

endmodule

// File: rtl/trace_checker.sv
// Compares expected retirement records against live commits
// and reports pass/fail with the first failing field.
module trace_checker
  import trace_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rec_valid,
  output logic             rec_ready,
  input  logic [3:0]       rec_flags,
  input  logic [15:0]      rec_pc,
  input  logic [2:0]       rec_reg,
  input  logic [15:0]      rec_wdata,
  input  logic [15:0]      rec_addr,
  input  logic [15:0]      rec_mdata,
  input  logic             c_valid,
  input  logic [15:0]      c_pc,
  input  logic [2:0]       c_reg,
  input  logic [15:0]      c_wdata,
  input  logic [15:0]      c_addr,
  input  logic [15:0]      c_mdata,
  input  logic             c_halt,
  input  logic             c_memread,
  input  logic             c_memwrite,
  input  logic             c_regwrite,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [2:0]       fail_code,
  output logic [CNT_W-1:0] fail_inum,
  output logic [CNT_W-1:0] inst_count,
  output logic [CNT_W-1:0] cycle_count
);

  state_t     state;
  rec_t       inRec;
  rec_t       head;
  rec_t       obs;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic       running;
  logic [2:0] code;

  assign inRec = '{flags: rec_flags, pc: rec_pc, rd: rec_reg,
                   wdata: rec_wdata, addr: rec_addr,
                   mdata: rec_mdata};
  assign obs = '{flags: {c_halt, c_memread, c_memwrite, c_regwrite},
                 pc: c_pc, rd: c_reg, wdata: c_wdata,
                 addr: c_addr, mdata: c_mdata};

  assign running   = (state == RUN);
  assign rec_ready = running && !full;
  assign push      = rec_valid && rec_ready;
  assign pop       = running && c_valid && !empty;
  assign code      = cmpRec(head, obs);
  assign done      = pass | fail;

  trace_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(rec_t))
  ) uFifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (inRec),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      pass        <= 1'b0;
      fail        <= 1'b0;
      fail_code   <= FC_NONE;
      fail_inum   <= '0;
      inst_count  <= '0;
      cycle_count <= '0;
    end else begin
      unique case (state)
        RUN: begin
          cycle_count <= cycle_count + CNT_W'(1);
          if (c_valid) begin
            inst_count <= inst_count + CNT_W'(1);
            if (empty) begin
              state     <= FAIL;
              fail      <= 1'b1;
              fail_code <= FC_UNDERFLOW;
              fail_inum <= inst_count;
            end else if (code != FC_NONE) begin
              state     <= FAIL;
              fail      <= 1'b1;
              fail_code <= code;
              fail_inum <= inst_count;
            end else if (head.flags[FL_HALT]) begin
              state <= PASS;
              pass  <= 1'b1;
            end
          end
        end
        PASS: state <= PASS;
        FAIL: state <= FAIL;
        default: state <= FAIL;
      endcase
    end
  end

endmodule

// File: tb/tb_trace_checker.sv
// Scoreboard bench for trace_checker: a queue-based reference
// predicts the verdict, a monitor checks it when done rises.
module tb_trace_checker;

  localparam int DEPTH = 4;
  localparam int CNT_W = 32;

  typedef struct packed {
    logic [3:0]  flags;
    logic [15:0] pc;
    logic [2:0]  rd;
    logic [15:0] wdata;
    logic [15:0] addr;
    logic [15:0] mdata;
  } trec_t;

  typedef struct {
    logic        p;
    logic        f;
    logic [2:0]  code;
    logic [31:0] inum;
    logic [31:0] inst;
  } verdict_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             rec_valid;
  logic             rec_ready;
  logic [3:0]       rec_flags;
  logic [15:0]      rec_pc;
  logic [2:0]       rec_reg;
  logic [15:0]      rec_wdata;
  logic [15:0]      rec_addr;
  logic [15:0]      rec_mdata;
  logic             c_valid;
  logic [15:0]      c_pc;
  logic [2:0]       c_reg;
  logic [15:0]      c_wdata;
  logic [15:0]      c_addr;
  logic [15:0]      c_mdata;
  logic             c_halt;
  logic             c_memread;
  logic             c_memwrite;
  logic             c_regwrite;
  logic             done;
  logic             pass;
  logic             fail;
  logic [2:0]       fail_code;
  logic [CNT_W-1:0] fail_inum;
  logic [CNT_W-1:0] inst_count;
  logic [CNT_W-1:0] cycle_count;

  int checks = 0;
  int errors = 0;

  trec_t    expRecs[$];
  trec_t    obsComs[$];
  trec_t    modelQ[$];
  verdict_t sbQ[$];

  // 0 running, 1 passed, 2 failed
  int          mState;
  logic [31:0] instM;
  logic [31:0] cycM;

  always #5 clk = ~clk;

  trace_checker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .rec_valid   (rec_valid),
    .rec_ready   (rec_ready),
    .rec_flags   (rec_flags),
    .rec_pc      (rec_pc),
    .rec_reg     (rec_reg),
    .rec_wdata   (rec_wdata),
    .rec_addr    (rec_addr),
    .rec_mdata   (rec_mdata),
    .c_valid     (c_valid),
    .c_pc        (c_pc),
    .c_reg       (c_reg),
    .c_wdata     (c_wdata),
    .c_addr      (c_addr),
    .c_mdata     (c_mdata),
    .c_halt      (c_halt),
    .c_memread   (c_memread),
    .c_memwrite  (c_memwrite),
    .c_regwrite  (c_regwrite),
    .done        (done),
    .pass        (pass),
    .fail        (fail),
    .fail_code   (fail_code),
    .fail_inum   (fail_inum),
    .inst_count  (inst_count),
    .cycle_count (cycle_count)
  );

  task automatic check(string name, logic [127:0] act,
                       logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic trec_t mk(logic [3:0] fl, logic [15:0] pc,
                               logic [2:0] rd, logic [15:0] wd,
                               logic [15:0] ad, logic [15:0] md);
    trec_t r;
    r.flags = fl; r.pc = pc; r.rd = rd;
    r.wdata = wd; r.addr = ad; r.mdata = md;
    return r;
  endfunction

  // Which fields count depends only on the expected flags.
  function automatic logic [2:0] refCode(trec_t e, trec_t c);
    bit [7:0] bad;
    bad = '0;
    bad[1] = (e.flags != c.flags);
    bad[2] = (e.pc != c.pc);
    bad[3] = e.flags[0] && (e.rd != c.rd);
    bad[4] = e.flags[0] && (e.wdata != c.wdata);
    bad[5] = (e.flags[2] || e.flags[1]) && (e.addr != c.addr);
    bad[6] = e.flags[1] && (e.mdata != c.mdata);
    for (int i = 1; i <= 6; i++)
      if (bad[i]) return 3'(i);
    return 3'd0;
  endfunction

  // Monitor: one verdict per rising done.
  initial begin
    bit seen;
    verdict_t v;
    seen = 0;
    forever begin
      @(negedge clk);
      if (done && !seen) begin
        seen = 1;
        if (sbQ.size() == 0) begin
          check("unexpected_done", {pass, fail}, 2'b00);
        end else begin
          v = sbQ.pop_front();
          check("verdict_pass", pass, v.p);
          check("verdict_fail", fail, v.f);
          check("verdict_code", fail_code, v.code);
          check("verdict_inum", fail_inum, v.inum);
          check("verdict_inst", inst_count, v.inst);
        end
      end
      if (!done) seen = 0;
    end
  end

  task automatic doReset();
    rst = 1'b1;
    rec_valid = 1'b1;
    c_valid = 1'b1;
    rec_flags = 4'h1;
    c_halt = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rec_valid = 1'b0;
    c_valid = 1'b0;
    modelQ.delete();
    sbQ.delete();
    mState = 0;
    instM = '0;
    cycM = '0;
    check("reset_state",
          {pass, fail, done, fail_code, fail_inum,
           inst_count, cycle_count, rec_ready},
          {3'b000, 3'd0, 32'd0, 32'd0, 32'd0, 1'b1});
  endtask

  task automatic runScenario(int pushPct, int comPct,
                             int comStart, int maxCyc);
    int ri;
    int ci;
    bit expReady;
    bit acc;
    trec_t r;
    trec_t c;
    trec_t h;
    logic [2:0] cd;
    verdict_t v;
    ri = 0;
    ci = 0;
    for (int cyc = 0; cyc < maxCyc; cyc++) begin
      r = (ri < expRecs.size()) ? expRecs[ri] : trec_t'(0);
      c = (ci < obsComs.size()) ? obsComs[ci] : trec_t'(0);
      rec_valid = (ri < expRecs.size()) &&
                  ($urandom_range(99) < pushPct);
      c_valid = (ci < obsComs.size()) && (cyc >= comStart) &&
                ($urandom_range(99) < comPct);
      {rec_flags, rec_pc, rec_reg, rec_wdata, rec_addr,
       rec_mdata} = r;
      {c_halt, c_memread, c_memwrite, c_regwrite} = c.flags;
      {c_pc, c_reg, c_wdata, c_addr, c_mdata} =
        {c.pc, c.rd, c.wdata, c.addr, c.mdata};
      @(negedge clk);
      expReady = (mState == 0) && (modelQ.size() < DEPTH);
      check("rec_ready", rec_ready, expReady);
      @(posedge clk);
      acc = rec_valid && expReady;
      if (c_valid) ci++;
      if (mState == 0) begin
        cycM++;
        if (c_valid) begin
          if (modelQ.size() == 0) begin
            cd = 3'd7;
          end else begin
            h = modelQ.pop_front();
            cd = refCode(h, c);
          end
          if (cd != 0) begin
            mState = 2;
            v = '{p: 1'b0, f: 1'b1, code: cd,
                  inum: instM, inst: instM + 1};
            sbQ.push_back(v);
          end else if (h.flags[3]) begin
            mState = 1;
            v = '{p: 1'b1, f: 1'b0, code: 3'd0,
                  inum: 32'd0, inst: instM + 1};
            sbQ.push_back(v);
          end
          instM++;
        end
      end
      if (acc) begin
        modelQ.push_back(r);
        ri++;
      end
      #1;
    end
    rec_valid = 1'b0;
    c_valid = 1'b0;
    @(negedge clk);
    check("end_state", {pass, fail},
          {mState == 1, mState == 2});
    check("end_inst", inst_count, instM);
    check("end_cycles", cycle_count, cycM);
    check("sb_drained", sbQ.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic planBase(bit badStore);
    trec_t s;
    expRecs.delete();
    obsComs.delete();
    expRecs.push_back(mk(4'b0001, 16'h0000, 3'd1, 16'h0005, 0, 0));
    expRecs.push_back(mk(4'b0010, 16'h0002, 0, 0,
                         16'h0010, 16'h1234));
    expRecs.push_back(mk(4'b1000, 16'h0004, 0, 0, 0, 0));
    obsComs = expRecs;
    if (badStore) begin
      s = obsComs[1];
      s.mdata = 16'h1235;
      obsComs[1] = s;
    end
  endtask

  initial begin
    trec_t t;
    int n;
    rst = 1'b1;
    rec_valid = 0; rec_flags = 0; rec_pc = 0; rec_reg = 0;
    rec_wdata = 0; rec_addr = 0; rec_mdata = 0;
    c_valid = 0; c_pc = 0; c_reg = 0; c_wdata = 0;
    c_addr = 0; c_mdata = 0;
    c_halt = 0; c_memread = 0; c_memwrite = 0; c_regwrite = 0;
    repeat (2) @(posedge clk);
    #1;

    doReset();
    planBase(0);
    runScenario(100, 100, 4, 12);

    doReset();
    planBase(1);
    runScenario(100, 100, 4, 12);

    doReset();
    expRecs.delete();
    obsComs.delete();
    obsComs.push_back(mk(4'b0001, 0, 1, 1, 0, 0));
    runScenario(0, 100, 0, 4);

    doReset();
    expRecs.delete();
    for (int i = 0; i < 5; i++)
      expRecs.push_back(mk((i == 3) ? 4'b1000 : 4'b0001,
                           16'(2 * i), 3'(i), 16'(i + 7), 0, 0));
    obsComs.delete();
    for (int i = 0; i < 4; i++) obsComs.push_back(expRecs[i]);
    runScenario(100, 100, 6, 14);

    doReset();
    expRecs.delete();
    obsComs.delete();
    expRecs.push_back(mk(4'b0000, 16'h0010, 3'd2, 16'h1111, 0, 0));
    expRecs.push_back(mk(4'b1000, 16'h0012, 0, 0, 0, 0));
    obsComs.push_back(mk(4'b0000, 16'h0010, 3'd5, 16'h2222, 0, 0));
    obsComs.push_back(mk(4'b1000, 16'h0012, 0, 0, 0, 0));
    runScenario(100, 100, 3, 10);

    doReset();
    planBase(1);
    runScenario(100, 100, 4, 8);
    doReset();
    expRecs.delete();
    expRecs.push_back(mk(4'b1000, 16'h0040, 0, 0, 0, 0));
    obsComs = expRecs;
    runScenario(100, 100, 2, 6);

    for (int it = 0; it < 40; it++) begin
      doReset();
      expRecs.delete();
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        t = trec_t'({$urandom, $urandom, $urandom});
        t.flags[3] = (i == n - 1);
        expRecs.push_back(t);
      end
      obsComs = expRecs;
      if ($urandom_range(1) == 1) begin
        int k;
        k = $urandom_range(n - 1);
        t = obsComs[k];
        case ($urandom_range(5))
          0: t.flags[$urandom_range(3)] ^= 1'b1;
          1: t.pc ^= 16'(1 << $urandom_range(15));
          2: t.rd ^= 3'd1;
          3: t.wdata ^= 16'(1 << $urandom_range(15));
          4: t.addr ^= 16'(1 << $urandom_range(15));
          default: t.mdata ^= 16'(1 << $urandom_range(15));
        endcase
        obsComs[k] = t;
      end
      runScenario($urandom_range(40, 100), $urandom_range(30, 100),
                  $urandom_range(5), 40);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/trace_checker.md
# trace_checker

Synthesizable retirement-trace checker that consumes expected commit records over a valid/ready stream. It compares each record against the processor's per-cycle commit signals: PC, register write, memory read/write, halt. It sits beside the pipelined processor in the `proc_hier` wrapper and is fed by a trace-record loader. It reports pass/fail in hardware, so regression needs no simulator-side trace diffing.

## Interface
Parameters:
- `DEPTH`, 4: expected-record FIFO entries; must be a power of 2 and at least 2.
- `CNT_W`, 32: width of instruction and cycle counters.

Ports:
- `clk` in 1: the design's single clock.
- `rst` in 1: reset, **synchronous and active-high**.
- `rec_valid` in 1: expected record valid.
- `rec_ready` out 1: checker accepts a record this cycle.
- `rec_flags` in 4: `{halt, memread, memwrite, regwrite}`.
- `rec_pc` in 16: expected PC.
- `rec_reg` in 3: expected destination register.
- `rec_wdata` in 16: expected register write value.
- `rec_addr` in 16: expected memory address.
- `rec_mdata` in 16: expected store data.
- `c_valid` in 1: one instruction commits this cycle.
- `c_pc`, `c_reg`, `c_wdata`, `c_addr`, `c_mdata` in 16/3/16/16/16: observed commit fields.
- `c_halt`, `c_memread`, `c_memwrite`, `c_regwrite` in 1 each: observed commit flags.
- `done` out 1: check finished, whether pass or fail.
- `pass` out 1: the halt record matched and there were no earlier mismatches.
- `fail` out 1: a mismatch or underflow occurred.
- `fail_code` out 3: first failing field.
- `fail_inum` out CNT_W: instruction number of the first failure, starting at 0.
- `inst_count` out CNT_W: commits checked so far.
- `cycle_count` out CNT_W: cycles since reset.

## Operation
- State machine states: `RUN`, `PASS`, `FAIL`. Reset enters `RUN`.
- Reset values of all outputs are 0. FIFO pointers clear. `rec_ready` is 1 in the first cycle after reset.
- `rec_ready = (state == RUN) && !fifo_full`. A record is pushed when `rec_valid && rec_ready`.
- `RUN` with `c_valid`:
  - If the FIFO is empty, go to `FAIL` with code 7 (underflow).
  - Otherwise, pop the head and compare it against the commit.
- Comparison rules, with the lowest-numbered mismatching code reported:
  - 1 flags: all 4 flags must be equal.
  - 2 pc: always compared.
  - 3 reg: compared only if regwrite.
  - 4 wdata: compared only if regwrite.
  - 5 addr: compared only if memread or memwrite.
  - 6 mdata: compared only if memwrite.
- Transitions after a compare:
  - Match with halt set: go to `PASS`.
  - Match without halt: stay in `RUN`.
  - Any mismatch: go to `FAIL`.
- On entering `FAIL`:
  - latch `fail_code`;
  - latch `fail_inum = inst_count`, the pre-increment value.
- `inst_count` increments on every `c_valid` handled in `RUN`, including a failing commit.
- `cycle_count` increments every cycle while in `RUN` and freezes in `PASS` or `FAIL`.
- `PASS` and `FAIL` are terminal until `rst`. In these states:
  - `c_valid` is ignored;
  - `rec_ready` is 0;
  - FIFO contents are don't-care.
- `done = pass | fail`. `pass` and `fail` are mutually exclusive.
- A commit with `c_halt = 1` against a non-halt record is code 1 (flags mismatch).

## Timing
- Compare is combinational on the FIFO head. State, flags, and counters register on the same clock edge as the commit.
- Consequently, `fail`/`pass` are visible the cycle after the offending or halting commit.
- Push and pop in the same cycle are allowed. The FIFO count is unchanged by a simultaneous push and pop.
- When the FIFO is full, `rec_ready` is 0, so a push and pop into a full FIFO cannot occur together.
- There is no push-to-pop bypass. A record pushed in cycle N is checkable from cycle N+1. A commit in cycle N against a FIFO empty before the push underflows.
- Pointers wrap modulo DEPTH. Full and empty are distinguished by an extra pointer MSB.
- `rst` mid-check dominates everything:
  - the next cycle is `RUN` with all outputs 0 and the FIFO empty;
  - a push or commit in the reset cycle is discarded.

## Structure
- Shared package `trace_pkg`:
  - flag bit index constants;
  - `fail_code` constants: `FC_NONE=0` … `FC_UNDERFLOW=7`;
  - the state encoding;
  - the packed record typedef (71 bits: flags, pc, reg, wdata, addr, mdata).
- One sub-module, `trace_fifo`:
  - parameterized `DEPTH` and width;
  - synchronous FIFO with full/empty outputs and head-data output.
- The top level holds the compare logic, the state machine, and the counters.

## Test plan
- Push 3 records (regwrite r1=0x0005 @PC 0x0000; store addr 0x0010 data 0x1234 @0x0002; halt @0x0004), then commit matching values on cycles 5, 6, 7:
  - `pass = 1` on cycle 8;
  - `inst_count = 3`;
  - `fail = 0`.
- Same sequence with commit 2 `c_mdata = 0x1235`:
  - `fail = 1` on the next cycle;
  - `fail_code = 6`;
  - `fail_inum = 1`;
  - later commits are ignored and `inst_count` stays 2.
- `c_valid` on the first cycle after reset with no records: `fail_code = 7`, `fail_inum = 0`.
- Hold `rec_valid` high for 6 cycles with DEPTH=4 and no commits:
  - `rec_ready` drops after 4 pushes;
  - then 4 matching commits (the 4th being halt) give `pass`.
- Record with regwrite=0 but differing `rec_reg`/`rec_wdata`: no failure, since those fields are not compared.
- Assert `rst` 2 cycles after a mismatch:
  - `fail`, `fail_code`, and counters return to 0;
  - a fresh 1-record halt sequence passes.
